panel_input: RTL and testbench
==============================

# panel_input

Front-panel key front end for the washing-machine controller: the input-side counterpart of the display/LED view block. Synchronises and debounces four raw push-buttons (power, start/pause, mode, water level), and turns each clean press into a one-cycle event pulse for the main controller FSM. Generates a power long-press event and a retriggerable key-beep enable. Sits between the board pins and the controller, in the same `cp` domain as the view logic.

## Interface
- `DEBOUNCE_CYCLES`, 20000: cycles a synchronised level must stay stable to be accepted; ≥2.
- `LONG_CYCLES`, 2000000: cycles the power key must be held, after debounce, to fire `powerLong`.
- `BEEP_CYCLES`, 50000: `keyBeep` high time after any event.
- `CNT_W`, 22: counter width; must hold max(`DEBOUNCE_CYCLES`, `LONG_CYCLES`, `BEEP_CYCLES`).

Ports:
- `cp`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `btnPower`, `btnStart`, `btnMode`, `btnLevel`, input, 1 each: raw keys, active-high, asynchronous to `cp`.
- `powerPress`, `startPress`, `modePress`, `levelPress`, output, 1 each: one-cycle press events.
- `powerLong`, output, 1: one-cycle power long-press event.
- `anyHeld`, output, 1: level, high while any key FSM is in HELD or RELEASE_WAIT.
- `keyBeep`, output, 1: beeper enable.

## Operation
- Each key has a 2-flop synchroniser (`s1`, `s2`). The FSM uses `s2` only.
- Each key has an independent FSM with its own `CNT_W` debounce counter `cnt`:
  - IDLE: if `s2`=1, go to PRESS_WAIT and set `cnt`=0.
  - PRESS_WAIT: if `s2`=0, return to IDLE. Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, go to HELD and fire the press event. Otherwise increment `cnt`.
  - HELD: if `s2`=0, go to RELEASE_WAIT and set `cnt`=0.
  - RELEASE_WAIT: if `s2`=1, return to HELD. If `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE (release accepted). Otherwise increment `cnt`.
- All event outputs are registered: high for exactly one cycle, in the cycle after the transition edge.
- Keys are fully independent. Several events may be high in the same cycle.
- Beep: any event (including `powerLong`) loads the beep counter with `BEEP_CYCLES`. `keyBeep` = (beep counter ≠ 0). The counter decrements to 0 and saturates there. A new event reloads it (retrigger).

## Timing
- Reset: all FSMs go to IDLE; all counters, synchronisers and outputs are 0. Reset is asynchronous and takes effect mid-press; no event fires after reset releases unless a new full debounce completes.
- Press latency: let edge 0 be the first `cp` edge that samples the raw key high, with the key held stable. The press event is high in the cycle following edge `DEBOUNCE_CYCLES`+2.
- A bounce during PRESS_WAIT restarts detection from IDLE. A bounce during RELEASE_WAIT returns to HELD with no new event.
- Release latency to IDLE: `DEBOUNCE_CYCLES`+2 edges after the first edge that samples the raw key low.
- A key held forever produces one press event only.

## Configuration
- Macro `PANEL_LONGPRESS_EN`.
- Defined: the power key has a hold counter. It clears on entry to HELD from PRESS_WAIT, counts in HELD and RELEASE_WAIT, and is not cleared by a release bounce.
  - When the hold counter reaches `LONG_CYCLES`-1, `powerLong` pulses once and `longFired` is set.
  - `powerPress` is moved to release: it fires on the RELEASE_WAIT→IDLE transition, and only if `longFired`=0.
  - `longFired` clears in IDLE.
- Not defined: `powerPress` behaves like the other keys (fires at debounce), `powerLong` is tied to 0, and no hold counter is built.

## Test plan
Common parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `BEEP_CYCLES`=8.
- Clean press: `btnStart` held high from edge 0 → `startPress` is high for exactly one cycle after edge 6, never again while held, and `keyBeep` is high for 8 cycles.
- Bounce: `btnMode` toggles with high pulses of 1–3 cycles for 30 cycles, then goes low → no `modePress` and `keyBeep` stays 0.
- Simultaneous keys: `btnLevel` and `btnStart` rise on the same edge → both pulses are high in the same cycle. A second press 3 cycles later on `btnMode` reloads the beep, so `keyBeep` stays high until 8 cycles after `modePress`.
- Long press (macro defined): `btnPower` held 40 cycles → `powerLong` pulses once, and no `powerPress` on release. A 10-cycle hold gives `powerPress` only, 6 cycles after release (macro undefined: `powerPress` 6 cycles after press, `powerLong` stays 0).
- Reset mid-press: assert `reset` during PRESS_WAIT of `btnStart` while the key stays high → outputs go to 0 immediately. After reset release, `startPress` fires once, 6 edges after the first edge that samples the key high.

Source files
------------

// File: rtl/panel_input.sv
// ---------------------------------------------------------------------------
// panel_input
//   Front-panel key front end for the washing-machine controller. Each of the
//   four raw push-buttons is synchronised and debounced, and every accepted
//   press becomes a one-cycle event for the main controller FSM. The block
//   also drives a retriggerable key-beep enable and, optionally, a power-key
//   long-press event.
//
//   Build option: define PANEL_LONGPRESS_EN to give the power key a hold
//   counter. With it, powerLong pulses after LONG_CYCLES of debounced hold,
//   and powerPress moves to the accepted release (only if no long press
//   fired). Without it, powerPress fires at debounce like the other keys and
//   powerLong is tied low.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a synchronised level must stay stable (>= 2)
//   LONG_CYCLES     : debounced power-key hold time for powerLong (>= 2)
//   BEEP_CYCLES     : keyBeep high time after any event
//   CNT_W           : counter width, must hold all three values above
//
// Ports
//   cp                                       : system clock
//   reset                                    : async, active-high reset
//   btnPower/btnStart/btnMode/btnLevel       : raw keys, active-high, async
//   powerPress/startPress/modePress/levelPress : one-cycle press events
//   powerLong                                : one-cycle long-press event
//   anyHeld                                  : some key is HELD/RELEASE_WAIT
//   keyBeep                                  : beeper enable
// ---------------------------------------------------------------------------
module panel_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 20000,
   parameter int unsigned LONG_CYCLES     = 2000000,
   parameter int unsigned BEEP_CYCLES     = 50000,
   parameter int unsigned CNT_W           = 22
) (
   input  logic cp,
   input  logic reset,
   input  logic btnPower,
   input  logic btnStart,
   input  logic btnMode,
   input  logic btnLevel,
   output logic powerPress,
   output logic startPress,
   output logic modePress,
   output logic levelPress,
   output logic powerLong,
   output logic anyHeld,
   output logic keyBeep
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_RELEASE_WAIT
   } key_state_t;

   // Key index: 0 power, 1 start, 2 mode, 3 level.
   localparam int NKEY = 4;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYCLES);

   // Elaboration-time guard against a counter too narrow for its limits.
   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 ||
       CNT_W < $clog2(DEBOUNCE_CYCLES + 1) ||
       CNT_W < $clog2(LONG_CYCLES + 1) ||
       CNT_W < $clog2(BEEP_CYCLES + 1)) begin : g_param_check
      $error("panel_input: inconsistent counter parameters");
   end

   logic [NKEY-1:0]  w_raw;
   logic [NKEY-1:0]  r_s1;
   logic [NKEY-1:0]  r_s2;
   key_state_t       r_state     [NKEY];
   key_state_t       w_state_nxt [NKEY];
   logic [CNT_W-1:0] r_cnt       [NKEY];
   logic [CNT_W-1:0] w_cnt_nxt   [NKEY];
   logic [NKEY-1:0]  w_pressed;    // PRESS_WAIT -> HELD this cycle
   logic [NKEY-1:0]  w_event;      // press event to register
   logic             w_long_fire;  // long-press event to register
   logic [NKEY-1:0]  r_press;
   logic             r_long;
   logic [CNT_W-1:0] r_beep;
   logic             w_any_held;

   assign w_raw = {btnLevel, btnMode, btnStart, btnPower};

   // Two-flop synchroniser; the FSMs only ever look at r_s2.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NKEY; k++) begin
            r_state[k] <= ST_IDLE;
            r_cnt[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < NKEY; k++) begin
            r_state[k] <= w_state_nxt[k];
            r_cnt[k]   <= w_cnt_nxt[k];
         end
      end
   end

   // Per-key debounce FSM. A bounce in PRESS_WAIT drops back to IDLE; a
   // bounce in RELEASE_WAIT drops back to HELD without a new event.
   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      w_pressed = '0;
      for (int k = 0; k < NKEY; k++) begin
         w_state_nxt[k] = r_state[k];
         w_cnt_nxt[k]   = r_cnt[k];
         case (r_state[k])
            ST_IDLE: begin
               if (r_s2[k]) begin
                  w_state_nxt[k] = ST_PRESS_WAIT;
                  w_cnt_nxt[k]   = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!r_s2[k]) begin
                  w_state_nxt[k] = ST_IDLE;
               end else if (r_cnt[k] == DEB_LAST) begin
                  w_state_nxt[k] = ST_HELD;
                  w_pressed[k]   = 1'b1;
               end else begin
                  w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!r_s2[k]) begin
                  w_state_nxt[k] = ST_RELEASE_WAIT;
                  w_cnt_nxt[k]   = '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (r_s2[k]) begin
                  w_state_nxt[k] = ST_HELD;
               end else if (r_cnt[k] == DEB_LAST) begin
                  w_state_nxt[k] = ST_IDLE;
               end else begin
                  w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
               end
            end
            default: w_state_nxt[k] = ST_IDLE;
         endcase
      end
   end

`ifdef PANEL_LONGPRESS_EN
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

   logic [CNT_W-1:0] r_hold;
   logic             r_long_fired;
   logic             w_power_held;
   logic             w_power_release;

   assign w_power_held    = (r_state[0] == ST_HELD) || (r_state[0] == ST_RELEASE_WAIT);
   assign w_power_release = (r_state[0] == ST_RELEASE_WAIT) && !r_s2[0] && (r_cnt[0] == DEB_LAST);
   // Fire on the edge where the hold counter reaches LONG_LAST.
   assign w_long_fire     = w_power_held && (r_hold == LONG_PRE) && !r_long_fired;

   // Hold counter saturates at LONG_LAST so it cannot wrap and refire; a
   // release bounce does not clear it.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         r_hold       <= '0;
         r_long_fired <= 1'b0;
      end else begin
         if (w_pressed[0]) begin
            r_hold <= '0;
         end else if (w_power_held && (r_hold != LONG_LAST)) begin
            r_hold <= r_hold + CNT_W'(1);
         end
         if (r_state[0] == ST_IDLE) begin
            r_long_fired <= 1'b0;
         end else if (w_long_fire) begin
            r_long_fired <= 1'b1;
         end
      end
   end

   // Power press moves to release and is suppressed once a long press fired
   // (including one firing on the very same edge).
   assign w_event[0] = w_power_release && !r_long_fired && !w_long_fire;
`else
   assign w_long_fire = 1'b0;
   assign w_event[0]  = w_pressed[0];
`endif

   assign w_event[NKEY-1:1] = w_pressed[NKEY-1:1];

   // Registered events plus the retriggerable beep counter.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         r_press <= '0;
         r_long  <= 1'b0;
         r_beep  <= '0;
      end else begin
         r_press <= w_event;
         r_long  <= w_long_fire;
         if ((|w_event) || w_long_fire) begin
            r_beep <= BEEP_LOAD;
         end else if (r_beep != '0) begin
            r_beep <= r_beep - CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_any_held = 1'b0;
      for (int k = 0; k < NKEY; k++) begin
         if ((r_state[k] == ST_HELD) || (r_state[k] == ST_RELEASE_WAIT)) begin
            w_any_held = 1'b1;
         end
      end
   end

   assign powerPress = r_press[0];
   assign startPress = r_press[1];
   assign modePress  = r_press[2];
   assign levelPress = r_press[3];
   assign powerLong  = r_long;
   assign anyHeld    = w_any_held;
   assign keyBeep    = (r_beep != '0);

endmodule

// File: tb/tb_panel_input.sv
// ---------------------------------------------------------------------------
// tb_panel_input
//   Directed bench for panel_input with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
//   BEEP_CYCLES=8. A behavioural model treats each key as "debounced level
//   flips after DEBOUNCE_CYCLES+1 consecutive synchronised samples that
//   disagree with it", with the long press timed from the accepted press
//   edge, and is compared with the DUT every cycle. Hand-computed edge
//   latencies and pulse counts pin the model to the intended timing.
//   Honours PANEL_LONGPRESS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_panel_input;

   localparam int D = 4;
   localparam int L = 20;
   localparam int B = 8;
`ifdef PANEL_LONGPRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic cp       = 1'b0;
   logic reset    = 1'b1;
   logic btnPower = 1'b0;
   logic btnStart = 1'b0;
   logic btnMode  = 1'b0;
   logic btnLevel = 1'b0;
   logic powerPress, startPress, modePress, levelPress;
   logic powerLong, anyHeld, keyBeep;

   panel_input #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .BEEP_CYCLES    (B),
      .CNT_W          (22)
   ) dut (
      .cp        (cp),
      .reset     (reset),
      .btnPower  (btnPower),
      .btnStart  (btnStart),
      .btnMode   (btnMode),
      .btnLevel  (btnLevel),
      .powerPress(powerPress),
      .startPress(startPress),
      .modePress (modePress),
      .levelPress(levelPress),
      .powerLong (powerLong),
      .anyHeld   (anyHeld),
      .keyBeep   (keyBeep)
   );

   always #5 cp = ~cp;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;          // posedge counter, advanced by the compare process

   // Tallies of observed DUT outputs: 0 power, 1 start, 2 mode, 3 level, 4 long.
   int ev_cnt  [5] = '{default: 0};
   int ev_last [5] = '{default: 0};
   int beep_hi   = 0;
   int beep_last = 0;

   // Snapshot of the tallies at the start of a scenario.
   int c0 [5];
   int b0;

   task automatic check(input string name, input int actual, input int expected);
      n_vec++;
      if (actual != expected) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic snap();
      c0 = ev_cnt;
      b0 = beep_hi;
   endtask

   // ---------------- model + per-cycle compare ----------------
   initial begin : model
      bit s1 [4];
      bit s2 [4];
      bit lvl [4];
      int run [4];
      bit raw [4];
      bit e_press [4];
      bit e_long, in_v, was_high, rise, fell, any_ev, any_lvl;
      int t0, beep;
      bit long_done;
      s1 = '{default: 0}; s2 = '{default: 0}; lvl = '{default: 0};
      run = '{default: 0};
      t0 = 0; beep = 0; long_done = 1'b0;
      forever begin
         @(posedge cp);
         cyc++;
         raw[0] = btnPower; raw[1] = btnStart; raw[2] = btnMode; raw[3] = btnLevel;
         e_press = '{default: 0};
         e_long  = 1'b0;
         if (reset) begin
            s1 = '{default: 0}; s2 = '{default: 0}; lvl = '{default: 0};
            run = '{default: 0};
            beep = 0; long_done = 1'b0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               in_v = s2[k];
               s2[k] = s1[k];
               s1[k] = raw[k];
               was_high = lvl[k];
               rise = 1'b0;
               fell = 1'b0;
               if (in_v != lvl[k]) begin
                  run[k]++;
                  if (run[k] == D + 1) begin
                     lvl[k] = in_v;
                     run[k] = 0;
                     rise = in_v;
                     fell = !in_v;
                  end
               end else begin
                  run[k] = 0;
               end
               if (k == 0 && LONG_EN) begin
                  if (rise) begin
                     t0 = cyc;
                     long_done = 1'b0;
                  end
                  if (was_high && !long_done && (cyc - t0 == L - 1)) begin
                     e_long = 1'b1;
                     long_done = 1'b1;
                  end
                  if (fell && !long_done) e_press[0] = 1'b1;
               end else if (rise) begin
                  e_press[k] = 1'b1;
               end
            end
            any_ev = e_long | e_press[0] | e_press[1] | e_press[2] | e_press[3];
            if (any_ev) beep = B;
            else if (beep > 0) beep--;
         end
         any_lvl = lvl[0] | lvl[1] | lvl[2] | lvl[3];
         #1;
         check("powerPress", powerPress, e_press[0]);
         check("startPress", startPress, e_press[1]);
         check("modePress",  modePress,  e_press[2]);
         check("levelPress", levelPress, e_press[3]);
         check("powerLong",  powerLong,  e_long);
         check("anyHeld",    anyHeld,    any_lvl);
         check("keyBeep",    keyBeep,    beep != 0);
         if (powerPress) begin ev_cnt[0]++; ev_last[0] = cyc; end
         if (startPress) begin ev_cnt[1]++; ev_last[1] = cyc; end
         if (modePress)  begin ev_cnt[2]++; ev_last[2] = cyc; end
         if (levelPress) begin ev_cnt[3]++; ev_last[3] = cyc; end
         if (powerLong)  begin ev_cnt[4]++; ev_last[4] = cyc; end
         if (keyBeep)    begin beep_hi++;   beep_last  = cyc; end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int e0, r0, t, hl, ll, i;

      // Reset state.
      repeat (3) @(negedge cp);
      check("reset_anyHeld",    anyHeld,    0);
      check("reset_keyBeep",    keyBeep,    0);
      check("reset_startPress", startPress, 0);
      check("reset_powerLong",  powerLong,  0);
      reset = 1'b0;
      repeat (3) @(negedge cp);

      // Clean press on start: event after edge 6, beep 8 cycles, one event only.
      snap();
      btnStart = 1'b1;
      e0 = cyc + 1;
      repeat (30) @(negedge cp);
      check("clean_count",    ev_cnt[1] - c0[1], 1);
      check("clean_latency",  ev_last[1] - e0,   6);
      check("clean_beep_len", beep_hi - b0,      8);
      btnStart = 1'b0;
      repeat (14) @(negedge cp);
      check("clean_no_release_event", ev_cnt[1] - c0[1], 1);

      // Bounce on mode: high pulses of 1..3 cycles never survive debounce.
      snap();
      t = 0;
      i = 0;
      while (t < 30) begin
         hl = 1 + (i % 3);
         ll = 1 + (i % 2);
         btnMode = 1'b1;
         repeat (hl) @(negedge cp);
         btnMode = 1'b0;
         repeat (ll) @(negedge cp);
         t += hl + ll;
         i++;
      end
      repeat (12) @(negedge cp);
      check("bounce_no_press", ev_cnt[2] - c0[2], 0);
      check("bounce_no_beep",  beep_hi - b0,      0);

      // Level and start together, mode 3 cycles later retriggers the beep.
      snap();
      btnLevel = 1'b1;
      btnStart = 1'b1;
      e0 = cyc + 1;
      repeat (3) @(negedge cp);
      btnMode = 1'b1;
      repeat (20) @(negedge cp);
      check("simul_level_count",   ev_cnt[3] - c0[3], 1);
      check("simul_start_count",   ev_cnt[1] - c0[1], 1);
      check("simul_level_latency", ev_last[3] - e0,   6);
      check("simul_start_latency", ev_last[1] - e0,   6);
      check("simul_mode_latency",  ev_last[2] - e0,   9);
      check("simul_beep_tail",     beep_last - ev_last[2], 7);
      check("simul_beep_len",      beep_hi - b0,      11);
      btnLevel = 1'b0;
      btnStart = 1'b0;
      btnMode  = 1'b0;
      repeat (14) @(negedge cp);

      // Power held 40 cycles.
      snap();
      btnPower = 1'b1;
      e0 = cyc + 1;
      repeat (40) @(negedge cp);
      btnPower = 1'b0;
      repeat (14) @(negedge cp);
`ifdef PANEL_LONGPRESS_EN
      check("long40_long_count",   ev_cnt[4] - c0[4], 1);
      check("long40_long_latency", ev_last[4] - e0,   25);
      check("long40_no_press",     ev_cnt[0] - c0[0], 0);
`else
      check("long40_press_count",   ev_cnt[0] - c0[0], 1);
      check("long40_press_latency", ev_last[0] - e0,   6);
      check("long40_no_long",       ev_cnt[4] - c0[4], 0);
`endif

      // Power held 10 cycles: short press only.
      snap();
      btnPower = 1'b1;
      e0 = cyc + 1;
      repeat (10) @(negedge cp);
      btnPower = 1'b0;
      r0 = cyc + 1;
      repeat (14) @(negedge cp);
      check("short_press_count", ev_cnt[0] - c0[0], 1);
      check("short_no_long",     ev_cnt[4] - c0[4], 0);
`ifdef PANEL_LONGPRESS_EN
      check("short_press_latency", ev_last[0] - r0, 6);
`else
      check("short_press_latency", ev_last[0] - e0, 6);
`endif

      // Reset during start's PRESS_WAIT, with level held and beeping.
      btnLevel = 1'b1;
      repeat (9) @(negedge cp);
      btnStart = 1'b1;
      repeat (3) @(negedge cp);
      check("pre_reset_anyHeld", anyHeld, 1);
      check("pre_reset_keyBeep", keyBeep, 1);
      reset = 1'b1;
      #1;
      check("midrst_anyHeld",    anyHeld,    0);
      check("midrst_keyBeep",    keyBeep,    0);
      check("midrst_startPress", startPress, 0);
      check("midrst_levelPress", levelPress, 0);
      snap();
      repeat (2) @(negedge cp);
      reset = 1'b0;
      e0 = cyc + 1;
      repeat (20) @(negedge cp);
      check("postrst_start_count",   ev_cnt[1] - c0[1], 1);
      check("postrst_start_latency", ev_last[1] - e0,   6);
      btnStart = 1'b0;
      btnLevel = 1'b0;
      repeat (14) @(negedge cp);
      check("final_anyHeld", anyHeld, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
